// File: rtl/cache_fill_pkg.sv
// cache_fill_pkg: shared state type and block geometry for the cache fill controller.
package cache_fill_pkg;

    typedef enum logic {IDLE, FILL} state_e;

    localparam int BLOCK_BYTES = 16;
    localparam int OFF_W = 3;
    localparam logic [31:0] BASE_MASK = ~32'(BLOCK_BYTES - 1);

endpackage

// File: rtl/cache_fill_if.sv
// cache_fill_if: cache/memory side signals of the fill controller; slave is the controller.
interface cache_fill_if #(
    parameter int ADDR_W = 16
);
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              memory_data_valid;
    logic [15:0]       memory_data;
    logic              fsm_busy;
    logic              mem_req;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic              write_tag_array;
    logic [ADDR_W-1:0] fill_word_addr;
    logic [15:0]       fill_data;
    logic              fill_done;

    modport slave (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, mem_req, memory_address, write_data_array,
               write_tag_array, fill_word_addr, fill_data, fill_done
    );

    modport master (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, mem_req, memory_address, write_data_array,
               write_tag_array, fill_word_addr, fill_data, fill_done
    );
endinterface

// File: rtl/cache_fill_ctr.sv
// cache_fill_ctr: word counter with enable and clear that saturates at MAX.
module cache_fill_ctr #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i && cnt_q != W'(MAX)) cnt_q <= cnt_q + 1'b1;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: streams a missing 16-byte block from memory into the cache arrays.
// CACHE_FILL_CRITICAL_WORD_FIRST_EN: start the fill at the missed word and wrap within the block.
module cache_fill_fsm
    import cache_fill_pkg::*;
#(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input logic         clk,
    input logic         rst,
    cache_fill_if.slave bus
);
    localparam int CW = OFF_W + 1;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CW-1:0]     req_cnt;
    logic [CW-1:0]     rcv_cnt;
    logic [OFF_W-1:0]  req_off;
    logic [OFF_W-1:0]  rcv_off;
    logic              fill;
    logic              start;
    logic              req;
    logic              wr;
    logic              last;

    assign fill  = state_q == FILL;
    // rst gate keeps busy low while reset is held with a pending miss
    assign start = state_q == IDLE && bus.miss_detected && !rst;
    assign req   = fill && req_cnt < CW'(BLOCK_WORDS);
    assign wr    = fill && bus.memory_data_valid;
    assign last  = wr && rcv_cnt == CW'(BLOCK_WORDS - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else if (start) begin
            state_q <= FILL;
            base_q  <= bus.miss_address & BASE_MASK[ADDR_W-1:0];
        end else if (last) begin
            state_q <= IDLE;
        end

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic [OFF_W-1:0] crit_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) crit_q <= '0;
        else if (start) crit_q <= bus.miss_address[OFF_W:1];

    assign req_off = crit_q + req_cnt[OFF_W-1:0];
    assign rcv_off = crit_q + rcv_cnt[OFF_W-1:0];
`else
    assign req_off = req_cnt[OFF_W-1:0];
    assign rcv_off = rcv_cnt[OFF_W-1:0];
`endif

    cache_fill_ctr #(.W(CW), .MAX(BLOCK_WORDS)) u_req_ctr (
        .clk(clk), .rst(rst), .en_i(req), .clr_i(!fill), .cnt_o(req_cnt)
    );

    cache_fill_ctr #(.W(CW), .MAX(BLOCK_WORDS)) u_rcv_ctr (
        .clk(clk), .rst(rst), .en_i(wr), .clr_i(!fill), .cnt_o(rcv_cnt)
    );

    assign bus.fsm_busy         = fill | start;
    assign bus.mem_req          = req;
    assign bus.memory_address   = base_q + ADDR_W'({req_off, 1'b0});
    assign bus.write_data_array = wr;
    assign bus.write_tag_array  = last;
    assign bus.fill_word_addr   = base_q + ADDR_W'({rcv_off, 1'b0});
    assign bus.fill_data        = bus.memory_data;
    assign bus.fill_done        = last;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed fills against a fixed-latency memory and a cycle-timeline model.
module tb_cache_fill_fsm;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_fill_if #(.ADDR_W(16)) bus ();
    cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    logic        sr_v[L];
    logic [15:0] sr_a[L];

    bit          m_fill;
    int          m_k, m_wr, m_crit;
    logic [15:0] m_base;

    int          tc, busy_cnt, busy_low, done_at, wr_seen;
    logic [15:0] done_fwa;
    logic [15:0] req_log[$];
    int          req_cyc[$];
    bit          saw_done;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic [15:0] exp_a0   = 16'h1236;
    logic [15:0] exp_afwa = 16'h1234;
    logic [15:0] exp_bfwa = 16'h1238;
    logic [15:0] exp_b[8] = '{16'h123A, 16'h123C, 16'h123E, 16'h1230,
                              16'h1232, 16'h1234, 16'h1236, 16'h1238};
`else
    logic [15:0] exp_a0   = 16'h1230;
    logic [15:0] exp_afwa = 16'h123E;
    logic [15:0] exp_bfwa = 16'h123E;
    logic [15:0] exp_b[8] = '{16'h1230, 16'h1232, 16'h1234, 16'h1236,
                              16'h1238, 16'h123A, 16'h123C, 16'h123E};
`endif

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, tc);
        end
    endtask

    // One clock: drive inputs, compare against the model, then advance model and memory.
    task automatic cycle(input bit miss, input logic [15:0] maddr, input bit r,
                         input bit ov, input logic [15:0] ovd);
        bit vin, eb, er, ew, ed;
        rst                   = r;
        bus.miss_detected     = miss;
        bus.miss_address      = maddr;
        vin                   = ov ? 1'b1 : sr_v[L-1];
        bus.memory_data_valid = vin;
        bus.memory_data       = ov ? ovd : (sr_a[L-1] ^ 16'h5A5A);
        #1;
        eb = !r && (m_fill || miss);
        er = !r && m_fill && m_k <= 8;
        ew = !r && m_fill && vin;
        ed = ew && m_wr == 7;
        chk("fsm_busy", bus.fsm_busy, eb);
        chk("mem_req", bus.mem_req, er);
        chk("write_data_array", bus.write_data_array, ew);
        chk("write_tag_array", bus.write_tag_array, ed);
        chk("fill_done", bus.fill_done, ed);
        chk("fill_data", bus.fill_data, bus.memory_data);
        if (er) chk("memory_address", bus.memory_address, m_base + 16'(2 * ((m_crit + m_k - 1) % 8)));
        if (ew) chk("fill_word_addr", bus.fill_word_addr, m_base + 16'(2 * ((m_crit + m_wr) % 8)));
        if (r) begin
            chk("rst_memory_address", bus.memory_address, 0);
            chk("rst_fill_word_addr", bus.fill_word_addr, 0);
        end
        if (bus.mem_req) begin
            req_log.push_back(bus.memory_address);
            req_cyc.push_back(tc);
        end
        if (bus.fsm_busy) busy_cnt++;
        else busy_low++;
        if (bus.write_data_array) wr_seen++;
        saw_done = bus.fill_done;
        if (bus.fill_done) begin
            done_at  = tc;
            done_fwa = bus.fill_word_addr;
        end
        if (r) m_fill = 0;
        else if (m_fill) begin
            if (ed) m_fill = 0;
            m_k++;
            m_wr += int'(ew);
        end else if (miss) begin
            m_fill = 1;
            m_k    = 1;
            m_wr   = 0;
            m_base = maddr & 16'hFFF0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            m_crit = int'(maddr[3:1]);
`else
            m_crit = 0;
`endif
        end
        for (int i = L - 1; i > 0; i--) begin
            sr_v[i] = sr_v[i-1];
            sr_a[i] = sr_a[i-1];
        end
        sr_v[0] = bus.mem_req;
        sr_a[0] = bus.memory_address;
        tc++;
        @(negedge clk);
    endtask

    task automatic clear_logs();
        tc       = 0;
        busy_cnt = 0;
        busy_low = 0;
        done_at  = -1;
        done_fwa = '0;
        wr_seen  = 0;
        req_log.delete();
        req_cyc.delete();
    endtask

    task automatic run_fill(input logic [15:0] addr);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cycle(1'b1, addr, 1'b0, 1'b0, 16'h0);
            ok = saw_done;
        end
        chk("fill_done_seen", ok, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        bus.miss_detected     = 1'b0;
        bus.miss_address      = '0;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = '0;
        for (int i = 0; i < L; i++) begin
            sr_v[i] = 1'b0;
            sr_a[i] = '0;
        end
        m_fill = 0;
        m_k    = 0;
        m_wr   = 0;
        m_crit = 0;
        m_base = '0;
        @(negedge clk);

        clear_logs();
        cycle(1'b1, 16'h1236, 1'b1, 1'b0, 16'h0);
        cycle(1'b1, 16'h1236, 1'b1, 1'b0, 16'h0);
        chk("reset_busy_cycles", busy_cnt, 0);
        chk("reset_requests", req_log.size(), 0);

        clear_logs();
        run_fill(16'h1236);
        chk("A_req_count", req_log.size(), 8);
        chk("A_req_first", req_log[0], exp_a0);
        chk("A_req_first_cycle", req_cyc[0], 1);
        chk("A_req_last_cycle", req_cyc[7], 8);
        chk("A_done_cycle", done_at, 12);
        chk("A_busy_cycles", busy_cnt, 13);
        chk("A_done_fill_addr", done_fwa, exp_afwa);
        chk("A_writes", wr_seen, 8);
        idle(3);

        clear_logs();
        run_fill(16'h123A);
        for (int i = 0; i < 8; i++) chk("B_req_order", req_log[i], exp_b[i]);
        chk("B_done_fill_addr", done_fwa, exp_bfwa);
        idle(2);

        clear_logs();
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'hBEEF);
        chk("idle_valid_writes", wr_seen, 0);
        chk("idle_valid_busy", busy_cnt, 0);
        idle(2);

        clear_logs();
        for (int i = 0; i < 7; i++) cycle(1'b1, 16'h3006, 1'b0, 1'b0, 16'h0);
        chk("abort_writes_before_rst", wr_seen, 2);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        chk("abort_writes_at_rst", wr_seen, 2);
        wr_seen = 0;
        idle(8);
        chk("abort_stale_writes", wr_seen, 0);

        clear_logs();
        run_fill(16'h2000);
        chk("C_req_first", req_log[0], 16'h2000);
        chk("C_req_last", req_log[7], 16'h200E);
        chk("C_done_fill_addr", done_fwa, 16'h200E);
        chk("C_done_cycle", done_at, 12);
        chk("C_writes", wr_seen, 8);
        idle(2);

        clear_logs();
        run_fill(16'h5000);
        tc      = 0;
        done_at = -1;
        req_log.delete();
        req_cyc.delete();
        run_fill(16'h4410);
        chk("D_busy_low_cycles", busy_low, 0);
        chk("D_req_first", req_log[0], 16'h4410);
        chk("D_req_first_cycle", req_cyc[0], 1);
        chk("D_done_cycle", done_at, 12);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
